// File: rtl/smg_scan_parmod.sv
// smg_scan_parmod -- multiplexed N_DIG-digit seven-segment driver.
//
// Scans N_DIG hex digits onto one shared 8-bit segment bus, with per-digit
// decimal points, optional leading-zero blanking and 16-level PWM brightness.
// New digit data is staged in a pending register and copied into the display
// register only at a frame boundary, so a frame never shows mixed data.
//
// Ports:
//   CLOCK    in   1        system clock, rising edge
//   RESET    in   1        asynchronous reset, active low
//   iCall    in   1        update request; samples iData/iDot/iLzb while high
//   iData    in   4*N_DIG  hex nibbles, nibble k = digit k (digit 0 rightmost)
//   iDot     in   N_DIG    decimal point per digit, 1 = lit
//   iLzb     in   1        leading-zero blanking enable
//   iBright  in   4        brightness, on-time (iBright+1)/16 of a slot
//   oDone    out  1        one-cycle pulse after the pending update is displayed
//   DIG      out  8        segments {dp,g,f,e,d,c,b,a}, polarity DIG_ACT_LOW
//   SEL      out  N_DIG    one-hot digit select, polarity SEL_ACT_LOW

// Per-digit decoder: hex nibble to active-high {dp,g..a}, with blanking.
module smg_digit #(
  parameter int IDX = 0
) (
  input  logic [3:0] nib,
  input  logic       dp,
  input  logic       lzb,
  input  logic       upper_zero,  // every nibble above this digit is zero
  output logic [7:0] seg
);
  // digit 0 always shows something, even when the whole value is zero
  localparam bit CAN_BLANK = (IDX != 0);

  logic [6:0] pat;
  logic       blank;

  always_comb begin
    pat = 7'h00;
    case (nib)
      4'h0: pat = 7'h3F;
      4'h1: pat = 7'h06;
      4'h2: pat = 7'h5B;
      4'h3: pat = 7'h4F;
      4'h4: pat = 7'h66;
      4'h5: pat = 7'h6D;
      4'h6: pat = 7'h7D;
      4'h7: pat = 7'h07;
      4'h8: pat = 7'h7F;
      4'h9: pat = 7'h6F;
      4'hA: pat = 7'h77;
      4'hB: pat = 7'h7C;
      4'hC: pat = 7'h39;
      4'hD: pat = 7'h5E;
      4'hE: pat = 7'h79;
      4'hF: pat = 7'h71;
      default: pat = 7'h00;
    endcase
  end

  assign blank = CAN_BLANK && lzb && (nib == 4'h0) && upper_zero;
  // the dp survives blanking
  assign seg   = {dp, blank ? 7'h00 : pat};
endmodule

module smg_scan_parmod #(
  parameter int N_DIG       = 6,
  parameter int T_SCAN      = 50000,
  parameter int SEL_ACT_LOW = 1,
  parameter int DIG_ACT_LOW = 1
) (
  input  logic               CLOCK,
  input  logic               RESET,
  input  logic               iCall,
  input  logic [4*N_DIG-1:0] iData,
  input  logic [N_DIG-1:0]   iDot,
  input  logic               iLzb,
  input  logic [3:0]         iBright,
  output logic               oDone,
  output logic [7:0]         DIG,
  output logic [N_DIG-1:0]   SEL
);
  // slot counter is kept as {phase, pcnt}: pcnt counts PRE clocks per PWM
  // phase, so no divider is needed to derive the phase
  localparam int PRE = T_SCAN / 16;
  localparam int PW  = (PRE > 1) ? $clog2(PRE) : 1;
  localparam int DW  = (N_DIG > 1) ? $clog2(N_DIG) : 1;
  localparam logic SEL_OFF = (SEL_ACT_LOW != 0);
  localparam logic DIG_OFF = (DIG_ACT_LOW != 0);

  typedef struct packed {
    logic [4*N_DIG-1:0] data;
    logic [N_DIG-1:0]   dot;
    logic               lzb;
  } frame_t;

  frame_t          pend, disp;
  logic            pend_vld;
  logic [PW-1:0]   pcnt;
  logic [3:0]      phase;
  logic [DW-1:0]   dig;
  logic            slot_end, frame_end, gap, cnt1, on;
  logic [1:0]      vld_pipe;
  logic [N_DIG:0]  zup;
  logic [N_DIG-1:0][7:0] seg_all;
  logic [7:0]      seg_on;
  logic [N_DIG-1:0] sel_oh;

  assign slot_end  = (phase == 4'hF) && (pcnt == PW'(PRE - 1));
  assign frame_end = slot_end && (dig == DW'(N_DIG - 1));
  assign gap       = (phase == 4'h0) && (pcnt == '0);
  // slot count 1; lets the lowest brightness stay visible even when a PWM
  // phase is one clock wide and the gap swallows all of phase 0
  assign cnt1      = (PRE == 1) ? ((phase == 4'h1) && (pcnt == '0))
                                : ((phase == 4'h0) && (pcnt == PW'(1)));
  assign on        = !gap && ((phase <= iBright) || cnt1);

  // scan counters
  always_ff @(posedge CLOCK or negedge RESET) begin
    if (!RESET) begin
      pcnt  <= '0;
      phase <= '0;
      dig   <= '0;
    end else begin
      if (pcnt == PW'(PRE - 1)) begin
        pcnt  <= '0;
        phase <= phase + 4'h1;
      end else begin
        pcnt <= pcnt + PW'(1);
      end
      if (slot_end)
        dig <= (dig == DW'(N_DIG - 1)) ? '0 : dig + DW'(1);
    end
  end

  // pending/display staging; a request on the boundary edge lands in pending
  // for the next frame while the previous pending moves to display
  always_ff @(posedge CLOCK or negedge RESET) begin
    if (!RESET) begin
      pend     <= '0;
      pend_vld <= 1'b0;
      disp     <= '0;
    end else begin
      if (iCall) begin
        pend     <= '{data: iData, dot: iDot, lzb: iLzb};
        pend_vld <= 1'b1;
      end else if (frame_end) begin
        pend_vld <= 1'b0;
      end
      if (frame_end && pend_vld)
        disp <= pend;
    end
  end

  assign vld_pipe[0] = frame_end && pend_vld;
  always_ff @(posedge CLOCK or negedge RESET) begin
    if (!RESET) vld_pipe[1] <= 1'b0;
    else        vld_pipe[1] <= vld_pipe[0];
  end
  assign oDone = vld_pipe[1];

  // zup[k]: nibbles k..N_DIG-1 of the display are all zero
  assign zup[N_DIG] = 1'b1;
  for (genvar k = 0; k < N_DIG; k++) begin : g_dig
    assign zup[k] = zup[k+1] && (disp.data[4*k +: 4] == 4'h0);
    smg_digit #(.IDX(k)) u_dig (
      .nib        (disp.data[4*k +: 4]),
      .dp         (disp.dot[k]),
      .lzb        (disp.lzb),
      .upper_zero (zup[k+1]),
      .seg        (seg_all[k])
    );
  end

  assign seg_on = on ? seg_all[dig] : 8'h00;
  assign sel_oh = on ? (N_DIG'(1) << dig) : '0;

  // registered outputs, one cycle behind the counter state
  always_ff @(posedge CLOCK or negedge RESET) begin
    if (!RESET) begin
      DIG <= {8{DIG_OFF}};
      SEL <= {N_DIG{SEL_OFF}};
    end else begin
      DIG <= DIG_OFF ? ~seg_on : seg_on;
      SEL <= SEL_OFF ? ~sel_oh : sel_oh;
    end
  end
endmodule

// File: tb/tb_smg_scan_parmod.sv
module tb_smg_scan_parmod;
  localparam int N = 4;
  localparam int T = 16;
  localparam int F = N * T;

  logic         clk = 1'b0;
  logic         rst_n = 1'b1;
  logic         icall = 1'b0;
  logic [15:0]  idata = '0;
  logic [3:0]   idot = '0;
  logic         ilzb = 1'b0;
  logic [3:0]   ibright = 4'hF;
  logic         odone;
  logic [7:0]   dig;
  logic [3:0]   sel;

  int total = 0;
  int bad = 0;
  int ndone = 0;
  int t = 0;

  // reference state
  logic [15:0] m_pd, m_dd;
  logic [3:0]  m_pdot, m_ddot;
  logic        m_plz, m_dlz, m_pv;
  logic [6:0]  tbl [16];

  smg_scan_parmod #(.N_DIG(N), .T_SCAN(T), .SEL_ACT_LOW(1), .DIG_ACT_LOW(1)) dut (
    .CLOCK(clk), .RESET(rst_n), .iCall(icall), .iData(idata), .iDot(idot),
    .iLzb(ilzb), .iBright(ibright), .oDone(odone), .DIG(dig), .SEL(sel)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h t=%0d", tag, obs, exp, t);
    end
  endtask

  task automatic model_reset();
    m_pd = '0; m_dd = '0; m_pdot = '0; m_ddot = '0;
    m_plz = 0; m_dlz = 0; m_pv = 0; t = 0;
  endtask

  // one clock: predict outputs from the pre-edge state, advance model, compare
  task automatic step();
    int c, k;
    logic on, blank;
    logic [3:0] nib;
    logic [7:0] s, e_dig;
    logic [3:0] e_sel;
    logic e_done;
    c = t % T;
    k = (t / T) % N;
    on = (c != 0) && (((c / (T / 16)) <= int'(ibright)) || c == 1);
    nib = m_dd[4*k +: 4];
    blank = m_dlz && (k != 0) && ((m_dd >> (4 * k)) == 16'h0);
    s = {m_ddot[k], blank ? 7'h00 : tbl[nib]};
    e_dig = on ? ~s : 8'hFF;
    e_sel = on ? ~(4'b0001 << k) : 4'hF;
    e_done = ((t % F) == F - 1) && m_pv;
    if (e_done) begin
      m_dd = m_pd; m_ddot = m_pdot; m_dlz = m_plz; m_pv = 0;
    end
    if (icall) begin
      m_pd = idata; m_pdot = idot; m_plz = ilzb; m_pv = 1;
    end
    t++;
    @(posedge clk);
    #1;
    chk("sel", 32'(sel), 32'(e_sel));
    chk("dig", 32'(dig), 32'(e_dig));
    chk("done", 32'(odone), 32'(e_done));
    if (odone) ndone++;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic call(input logic [15:0] d, input logic [3:0] dp, input logic lz);
    idata = d; idot = dp; ilzb = lz; icall = 1'b1;
    step();
    icall = 1'b0;
  endtask

  initial begin
    tbl = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
            7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};
    model_reset();

    // reset state
    #1 rst_n = 1'b0;
    #1;
    chk("rst_sel_async", 32'(sel), 32'hF);
    chk("rst_dig_async", 32'(dig), 32'hFF);
    repeat (3) @(posedge clk);
    #1;
    chk("rst_sel", 32'(sel), 32'hF);
    chk("rst_dig", 32'(dig), 32'hFF);
    chk("rst_done", 32'(odone), 32'h0);
    @(negedge clk) rst_n = 1'b1;

    // zeros on all digits, scan order 0..3
    run(2 * F);

    // single update mid-frame
    run(20);
    ndone = 0;
    call(16'h12AF, 4'b0100, 1'b0);
    run(2 * F);
    chk("one_done_12AF", 32'(ndone), 32'd1);

    // two requests in one frame: last wins, one done
    run(F - (t % F) + 5);
    ndone = 0;
    call(16'h1111, 4'b0000, 1'b0);
    run(7);
    call(16'h2222, 4'b0000, 1'b0);
    run(2 * F);
    chk("one_done_2222", 32'(ndone), 32'd1);

    // leading-zero blanking
    call(16'h0050, 4'b0000, 1'b1);
    run(2 * F);
    call(16'h0000, 4'b0000, 1'b1);
    run(2 * F);
    call(16'h0000, 4'b1010, 1'b1);
    run(2 * F);

    // brightness levels
    call(16'h8888, 4'b1111, 1'b0);
    run(2 * F);
    ibright = 4'd0;  run(F);
    ibright = 4'd7;  run(F);
    ibright = 4'd15; run(F);

    // randomized traffic, including requests that land on boundary edges
    for (int i = 0; i < 8 * F; i++) begin
      if ((i % T) == 3) ibright = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 19) == 0 || (i % F) == F - 1) begin
        idata = 16'($urandom); idot = 4'($urandom); ilzb = 1'($urandom);
        icall = 1'b1;
      end else begin
        icall = 1'b0;
      end
      step();
    end
    icall = 1'b0;
    ibright = 4'hF;
    run(F);

    // async reset mid-slot with an update pending
    run(F - (t % F) + 6);
    call(16'hBEEF, 4'b0001, 1'b0);
    run(3);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_sel", 32'(sel), 32'hF);
    chk("mid_rst_dig", 32'(dig), 32'hFF);
    chk("mid_rst_done", 32'(odone), 32'h0);
    repeat (2) @(posedge clk);
    #1;
    chk("mid_rst_sel_hold", 32'(sel), 32'hF);
    model_reset();
    @(negedge clk) rst_n = 1'b1;
    ndone = 0;
    run(3 * F);
    chk("no_done_after_rst", 32'(ndone), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
